// File: rtl/branch_gshare_predictor.sv
// Global-history branch direction predictor: PHT of saturating counters indexed by
// folded PC hashed with a speculative GHR, with retire-time training and GHR recovery.
module branch_gshare_predictor #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned GHR_BITS   = 4,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned HASH_MODE  = 0,
  parameter int unsigned SPEC_GHR   = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic                  pred_valid,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  output logic [GHR_BITS-1:0]   pred_ghr,
  output logic                  ready,
  input  logic                  update_en,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic [GHR_BITS-1:0]   update_ghr,
  input  logic                  update_taken,
  input  logic                  update_mispredict
);

  localparam int unsigned DEPTH   = 1 << INDEX_BITS;
  localparam int unsigned FOLD_W  = (HASH_MODE != 0) ? INDEX_BITS : INDEX_BITS - GHR_BITS;
  localparam int unsigned N_CHUNK = (PC_WIDTH + FOLD_W - 1) / FOLD_W;
  localparam int unsigned PAD_W   = N_CHUNK * FOLD_W;
  localparam logic [CTR_BITS-1:0] CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] init_cnt_q;
  logic [GHR_BITS-1:0]   ghr_q, ghr_d;
  logic [CTR_BITS-1:0]   pht [DEPTH];

  logic [PAD_W-1:0]      pc_pad;
  logic [FOLD_W-1:0]     fold;
  logic [CTR_BITS-1:0]   rd_ctr;
  logic [CTR_BITS-1:0]   upd_ctr;
  logic                  pht_we;
  logic [INDEX_BITS-1:0] pht_waddr;
  logic [CTR_BITS-1:0]   pht_wdata;

  // XOR-fold the PC into FOLD_W-bit chunks; the top chunk is zero-padded
  always_comb begin
    pc_pad = PAD_W'(pc);
    fold   = '0;
    for (int c = 0; c < N_CHUNK; c++) begin
      fold = fold ^ FOLD_W'(pc_pad >> (c * FOLD_W));
    end
  end

  generate
    if (HASH_MODE != 0) begin : g_xor_hash
      assign pred_index = fold ^ INDEX_BITS'(ghr_q);
    end else begin : g_cat_hash
      assign pred_index = {fold, ghr_q};
    end
  endgenerate

  assign ready      = (state_q == ST_RUN);
  assign rd_ctr     = pht[pred_index];
  assign pred_taken = ready & rd_ctr[CTR_BITS-1];
  assign pred_ghr   = ghr_q;
  assign upd_ctr    = pht[update_index];

  // Next state, PHT write port and GHR next value
  always_comb begin
    state_d   = state_q;
    pht_we    = 1'b0;
    pht_waddr = init_cnt_q;
    pht_wdata = CTR_WNT;
    ghr_d     = ghr_q;

    case (state_q)
      ST_INIT: begin
        pht_we = 1'b1;
        if (init_cnt_q == INDEX_BITS'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (update_en) begin
          pht_we    = 1'b1;
          pht_waddr = update_index;
          if (update_taken)
            pht_wdata = (upd_ctr == '1) ? upd_ctr : upd_ctr + CTR_BITS'(1);
          else
            pht_wdata = (upd_ctr == '0) ? upd_ctr : upd_ctr - CTR_BITS'(1);
        end

        // Recovery from a mispredict overrides any same-cycle speculative shift
        if (update_en && update_mispredict)
          ghr_d = {update_ghr[GHR_BITS-2:0], update_taken};
        else if ((SPEC_GHR != 0) && pred_valid)
          ghr_d = {ghr_q[GHR_BITS-2:0], pred_taken};
        else if ((SPEC_GHR == 0) && update_en)
          ghr_d = {ghr_q[GHR_BITS-2:0], update_taken};
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q <= state_d;
      ghr_q   <= ghr_d;
      if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + INDEX_BITS'(1);
    end
  end

  // Counter table has no reset; the init sweep establishes its contents
  always_ff @(posedge clk) begin
    if (pht_we) pht[pht_waddr] <= pht_wdata;
  end

endmodule

// File: tb/tb_branch_gshare_predictor.sv
// Self-checking bench for branch_gshare_predictor: directed init/hash/saturation/
// recovery/collision/reset steps plus randomized traffic against a table model.
module tb_branch_gshare_predictor;

  localparam int unsigned IB    = 8;
  localparam int unsigned GB    = 4;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] P     = 32'h12345678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic [31:0]   pc;
  logic          pred_valid, pred_taken, ready;
  logic [IB-1:0] pred_index, update_index;
  logic [GB-1:0] pred_ghr, update_ghr;
  logic          update_en, update_taken, update_mispredict;

  logic [31:0]   pc_h;
  logic          pred_valid_h, pred_taken_h, ready_h;
  logic [IB-1:0] pred_index_h, update_index_h;
  logic [GB-1:0] pred_ghr_h, update_ghr_h;
  logic          update_en_h, update_taken_h, update_mispredict_h;

  branch_gshare_predictor dut (
    .clk(clk), .resetn(resetn), .pc(pc), .pred_valid(pred_valid),
    .pred_taken(pred_taken), .pred_index(pred_index), .pred_ghr(pred_ghr),
    .ready(ready), .update_en(update_en), .update_index(update_index),
    .update_ghr(update_ghr), .update_taken(update_taken),
    .update_mispredict(update_mispredict)
  );

  branch_gshare_predictor #(.HASH_MODE(1)) dut_xor (
    .clk(clk), .resetn(resetn), .pc(pc_h), .pred_valid(pred_valid_h),
    .pred_taken(pred_taken_h), .pred_index(pred_index_h), .pred_ghr(pred_ghr_h),
    .ready(ready_h), .update_en(update_en_h), .update_index(update_index_h),
    .update_ghr(update_ghr_h), .update_taken(update_taken_h),
    .update_mispredict(update_mispredict_h)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: plain counter values 0..3 and history as an integer
  int m_pht [DEPTH];
  int m_ghr;
  int q_idx[$];
  int q_ghr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_fold(input logic [31:0] p, input int h);
    int f = 0;
    for (int c = 0; c * h < 32; c++) f = f ^ int'((p >> (c * h)) & ((32'd1 << h) - 32'd1));
    return f;
  endfunction

  function automatic int m_idx(input logic [31:0] p, input int g, input int mode);
    if (mode == 0) return (m_fold(p, IB - GB) << GB) | g;
    return m_fold(p, IB) ^ g;
  endfunction

  task automatic m_init();
    for (int i = 0; i < DEPTH; i++) m_pht[i] = 1;
    m_ghr = 0;
    q_idx.delete();
    q_ghr.delete();
  endtask

  // One RUN cycle on the main instance: drive, check outputs, advance the model
  task automatic step(input logic pv, input logic [31:0] p, input logic ue,
                      input logic [7:0] ui, input logic [3:0] ug,
                      input logic ut, input logic um);
    int idx, ptk, c;
    @(negedge clk);
    pred_valid = pv; pc = p; update_en = ue; update_index = ui;
    update_ghr = ug; update_taken = ut; update_mispredict = um;
    #2;
    idx = m_idx(p, m_ghr, 0);
    ptk = (m_pht[idx] >= 2) ? 1 : 0;
    chk("ready", 32'(ready), 32'd1);
    chk("pred_index", 32'(pred_index), 32'(idx));
    chk("pred_ghr", 32'(pred_ghr), 32'(m_ghr));
    chk("pred_taken", 32'(pred_taken), 32'(ptk));
    if (ue) begin
      c = m_pht[int'(ui)];
      m_pht[int'(ui)] = ut ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
    end
    if (ue && um) m_ghr = ((int'(ug) << 1) | int'(ut)) & 15;
    else if (pv)  m_ghr = ((m_ghr << 1) | ptk) & 15;
  endtask

  task automatic idle(input logic [31:0] p);
    step(1'b0, p, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
  endtask

  // Count clock edges until ready rises, with stray requests that must be ignored
  task automatic wait_init(output int n);
    n = 0;
    pred_valid = 1'b1; update_en = 1'b1; update_mispredict = 1'b1;
    update_taken = 1'b1; update_ghr = 4'hF; update_index = 8'h80;
    while (ready !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
      pc = $urandom;
      if (ready !== 1'b1 && (n % 64) == 0) chk("init_pred_taken", 32'(pred_taken), 32'd0);
    end
    pred_valid = 1'b0; update_en = 1'b0; update_mispredict = 1'b0; update_taken = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, pidx, c;
    logic pv, ue, ut, um;
    logic [31:0] p;
    logic [7:0] ui;
    logic [3:0] ug;
    logic [31:0] pcs [4];

    resetn = 1'b0; pc = P; pred_valid = 1'b0; update_en = 1'b0; update_index = '0;
    update_ghr = '0; update_taken = 1'b0; update_mispredict = 1'b0;
    pc_h = P; pred_valid_h = 1'b0; update_en_h = 1'b0; update_index_h = '0;
    update_ghr_h = '0; update_taken_h = 1'b0; update_mispredict_h = 1'b0;
    pcs[0] = P; pcs[1] = 32'h0000_1000; pcs[2] = 32'hDEAD_BEEF; pcs[3] = 32'h0040_0A04;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_pred_taken", 32'(pred_taken), 32'd0);
    chk("rst_pred_ghr", 32'(pred_ghr), 32'd0);
    chk("rst_ready_xor", 32'(ready_h), 32'd0);

    // Init sweep length
    @(negedge clk);
    resetn = 1'b1;
    wait_init(n);
    chk("init_len", 32'(n), 32'd256);
    chk("init_ghr_held", 32'(pred_ghr), 32'd0);
    chk("init_ready_xor", 32'(ready_h), 32'd1);
    m_init();
    for (int i = 0; i < 12; i++) begin
      idle($urandom);
      chk("post_init_pt", 32'(pred_taken), 32'd0);
    end

    // Concatenation hash
    idle(P);
    chk("hash_cat_idx", 32'(pred_index), 32'h80);
    chk("hash_cat_pt", 32'(pred_taken), 32'd0);

    // XOR hash with GHR set to 0011 through a recovery update
    @(negedge clk);
    update_en_h = 1'b1; update_mispredict_h = 1'b1; update_ghr_h = 4'b0001; update_taken_h = 1'b1;
    @(negedge clk);
    update_en_h = 1'b0; update_mispredict_h = 1'b0; update_taken_h = 1'b0; pc_h = P;
    #2;
    chk("hash_xor_ghr", 32'(pred_ghr_h), 32'h3);
    chk("hash_xor_idx", 32'(pred_index_h), 32'h0B);
    chk("hash_xor_pt", 32'(pred_taken_h), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pc_h = $urandom;
      #2;
      chk("hash_xor_rand", 32'(pred_index_h), 32'(m_idx(pc_h, 3, 1)));
    end

    // Counter saturation at 0x80
    step(1'b0, P, 1'b1, 8'h80, 4'h0, 1'b1, 1'b0);
    chk("sat_t0_pt", 32'(pred_taken), 32'd0);
    step(1'b0, P, 1'b1, 8'h80, 4'h0, 1'b1, 1'b0);
    chk("sat_t1_pt", 32'(pred_taken), 32'd1);
    step(1'b0, P, 1'b1, 8'h80, 4'h0, 1'b1, 1'b0);
    idle(P);
    chk("sat_hi_pt", 32'(pred_taken), 32'd1);
    step(1'b0, P, 1'b1, 8'h80, 4'h0, 1'b0, 1'b0);
    step(1'b0, P, 1'b1, 8'h80, 4'h0, 1'b0, 1'b0);
    chk("sat_nt1_pt", 32'(pred_taken), 32'd1);
    step(1'b0, P, 1'b1, 8'h80, 4'h0, 1'b0, 1'b0);
    chk("sat_nt2_pt", 32'(pred_taken), 32'd0);
    step(1'b0, P, 1'b1, 8'h80, 4'h0, 1'b0, 1'b0);
    idle(P);
    chk("sat_lo_pt", 32'(pred_taken), 32'd0);

    // Speculative shift, then recovery wins over a same-cycle shift
    for (int i = 0; i < 3; i++) step(1'b0, P, 1'b1, 8'h80, 4'h0, 1'b1, 1'b0);
    step(1'b1, P, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    chk("spec_pt", 32'(pred_taken), 32'd1);
    step(1'b1, P, 1'b1, 8'h80, 4'h0, 1'b0, 1'b1);
    chk("spec_ghr", 32'(pred_ghr), 32'h1);
    idle(P);
    chk("recover_ghr", 32'(pred_ghr), 32'h0);

    // Same-index predict and update
    step(1'b0, P, 1'b1, 8'h80, 4'h0, 1'b0, 1'b0);
    step(1'b1, P, 1'b1, 8'h80, 4'h0, 1'b1, 1'b0);
    chk("collide_now_pt", 32'(pred_taken), 32'd0);
    idle(P);
    chk("collide_next_pt", 32'(pred_taken), 32'd1);

    // Randomized traffic with retire replaying earlier predictions
    for (int i = 0; i < 300; i++) begin
      pv = 1'($urandom_range(1));
      p  = ($urandom_range(2) == 0) ? $urandom : pcs[$urandom_range(3)];
      ue = 1'($urandom_range(1));
      ut = 1'($urandom_range(1));
      um = ($urandom_range(3) == 0);
      if (ue && q_idx.size() > 0) begin
        ui = 8'(q_idx.pop_front());
        ug = 4'(q_ghr.pop_front());
      end else begin
        ui = 8'($urandom);
        ug = 4'($urandom);
      end
      if (pv) begin
        pidx = m_idx(p, m_ghr, 0);
        q_idx.push_back(pidx);
        q_ghr.push_back(m_ghr);
      end
      step(pv, p, ue, ui, ug, ut, um);
    end

    // Asynchronous reset in RUN with GHR=1010
    step(1'b0, P, 1'b1, 8'h80, 4'b0101, 1'b0, 1'b1);
    idle(P);
    chk("pre_rst_ghr", 32'(pred_ghr), 32'hA);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_rst_ready", 32'(ready), 32'd0);
    chk("async_rst_ghr", 32'(pred_ghr), 32'd0);
    chk("async_rst_pt", 32'(pred_taken), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Reset again mid-sweep; the sweep restarts from entry 0
    repeat (100) @(posedge clk);
    #1;
    chk("mid_sweep_ready", 32'(ready), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    wait_init(n);
    chk("reinit_len", 32'(n), 32'd256);
    m_init();
    for (int i = 0; i < 8; i++) begin
      idle(pcs[i % 4]);
      chk("reinit_pt", 32'(pred_taken), 32'd0);
    end
    c = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
